// File: rtl/instruction_fetch_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : instruction_fetch_stage_pkg
//  Purpose  : Shared types and constants for the RV64I fetch stage: machine
//             widths, fetch state encoding, the canonical NOP word and a
//             word-alignment helper.
//  Revision : 1.0  initial release
// ============================================================================
package instruction_fetch_stage_pkg;

    localparam int XLEN = 64;
    localparam int ILEN = 32;

    // addi x0, x0, 0
    localparam logic [ILEN-1:0] c_NOP_INSTR = 32'h0000_0013;

    typedef enum logic [0:0] {
        FETCH_RUN    = 1'b0,
        FETCH_HALTED = 1'b1
    } fetch_state_e;

    // Instruction fetches are always word aligned; low two bits are dropped.
    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return addr & ~64'h3;
    endfunction

endpackage
`default_nettype wire

// File: rtl/instruction_fetch_stage_if.sv
`default_nettype none
// ============================================================================
//  Module   : instruction_fetch_stage_if
//  Purpose  : Bundles the fetch stage's control inputs, instruction-memory
//             port and IF/ID outputs.
//  Modports : master - the fetch stage (drives address, IF/ID, status)
//             slave  - the surrounding core / memory (drives control, word)
//  Signals  : Stall, Branch_Taken, Branch_Target[63:0], Instruction[31:0] (to
//             stage); Inst_Address[63:0], IF_ID_PC[63:0],
//             IF_ID_Instruction[31:0], IF_ID_Valid, Halted, Fetch_Count[31:0]
//             (from stage)
//  Revision : 1.0  initial release
// ============================================================================
interface instruction_fetch_stage_if;
    import instruction_fetch_stage_pkg::*;

    logic            Stall;
    logic            Branch_Taken;
    logic [XLEN-1:0] Branch_Target;
    logic [XLEN-1:0] Inst_Address;
    logic [ILEN-1:0] Instruction;
    logic [XLEN-1:0] IF_ID_PC;
    logic [ILEN-1:0] IF_ID_Instruction;
    logic            IF_ID_Valid;
    logic            Halted;
    logic [31:0]     Fetch_Count;

    modport master (
        input  Stall, Branch_Taken, Branch_Target, Instruction,
        output Inst_Address, IF_ID_PC, IF_ID_Instruction, IF_ID_Valid,
               Halted, Fetch_Count
    );

    modport slave (
        output Stall, Branch_Taken, Branch_Target, Instruction,
        input  Inst_Address, IF_ID_PC, IF_ID_Instruction, IF_ID_Valid,
               Halted, Fetch_Count
    );

endinterface
`default_nettype wire

// File: rtl/instruction_fetch_stage_if_id_register.sv
`default_nettype none
// ============================================================================
//  Module   : if_id_register
//  Purpose  : IF/ID pipeline register holding PC, instruction word and valid.
//             Priority: reset > flush > hold > load. Flush injects a bubble
//             (NOP, valid=0) and leaves the stored PC untouched.
//  Ports    : clk, reset (sync, active-high), i_load, i_hold, i_flush,
//             i_pc[63:0], i_instruction[31:0] -> o_pc, o_instruction, o_valid
//  Revision : 1.0  initial release
// ============================================================================
module if_id_register
    import instruction_fetch_stage_pkg::*;
#(
    parameter logic [ILEN-1:0] NOP_INSTR = c_NOP_INSTR
) (
    input  wire logic            clk,
    input  wire logic            reset,
    input  wire logic            i_load,
    input  wire logic            i_hold,
    input  wire logic            i_flush,
    input  wire logic [XLEN-1:0] i_pc,
    input  wire logic [ILEN-1:0] i_instruction,
    output logic      [XLEN-1:0] o_pc,
    output logic      [ILEN-1:0] o_instruction,
    output logic                 o_valid
);

    logic [XLEN-1:0] r_pc;
    logic [ILEN-1:0] r_instruction;
    logic            r_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc          <= '0;
            r_instruction <= NOP_INSTR;
            r_valid       <= 1'b0;
        end else if (i_flush) begin
            r_instruction <= NOP_INSTR;
            r_valid       <= 1'b0;
        end else if (!i_hold && i_load) begin
            r_pc          <= i_pc;
            r_instruction <= i_instruction;
            r_valid       <= 1'b1;
        end
    end

    assign o_pc          = r_pc;
    assign o_instruction = r_instruction;
    assign o_valid       = r_valid;

endmodule
`default_nettype wire

// File: rtl/instruction_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : instruction_fetch_stage
//  Purpose  : RV64I fetch stage. Owns the PC, presents it to a combinational
//             instruction memory, captures the returned word into IF/ID one
//             clock later. Handles stall, branch redirect with wrong-path
//             flush, and halts when a fetch would read past MEM_BYTES.
//  Ports    : clk, reset (sync, active-high)
//             bus (instruction_fetch_stage_if.master): Stall, Branch_Taken,
//             Branch_Target, Instruction in; Inst_Address, IF_ID_PC,
//             IF_ID_Instruction, IF_ID_Valid, Halted, Fetch_Count out
//  Revision : 1.0  initial release
// ============================================================================
module instruction_fetch_stage
    import instruction_fetch_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = 64'h0,
    parameter logic [XLEN-1:0] MEM_BYTES = 64'd80,
    parameter logic [ILEN-1:0] NOP_INSTR = c_NOP_INSTR
) (
    input  wire logic               clk,
    input  wire logic               reset,
    instruction_fetch_stage_if.master bus
);

    localparam logic [0:0] c_RUN    = 1'(FETCH_RUN);
    localparam logic [0:0] c_HALTED = 1'(FETCH_HALTED);

    logic [XLEN-1:0] r_pc;
    logic [0:0]      r_state;
    logic [31:0]     r_fetch_count;

    logic [XLEN:0]   w_last_byte;
    logic            w_in_range;
    logic            w_capture;
    logic            w_flush;
    logic            w_hold;
    logic            w_halt;

    // Address of the last byte of the word at PC, one bit wider so the top
    // word of the address space cannot wrap around and look in range.
    assign w_last_byte = {1'b0, r_pc} + 65'd3;
    assign w_in_range  = (w_last_byte < {1'b0, MEM_BYTES});

    // Per-edge decision; the branch redirect outranks stall and halt.
    always_comb begin
        w_capture = 1'b0;
        w_flush   = 1'b0;
        w_hold    = 1'b0;
        w_halt    = 1'b0;
        if (bus.Branch_Taken) begin
            w_flush = 1'b1;
        end else if (r_state == c_HALTED) begin
            w_hold = 1'b1;
        end else if (bus.Stall) begin
            w_hold = 1'b1;
        end else if (w_in_range) begin
            w_capture = 1'b1;
        end else begin
            w_flush = 1'b1;
            w_halt  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc          <= RESET_PC;
            r_state       <= c_RUN;
            r_fetch_count <= '0;
        end else begin
            if (bus.Branch_Taken) begin
                r_pc    <= align_word(bus.Branch_Target);
                r_state <= c_RUN;
            end else if (w_halt) begin
                r_state <= c_HALTED;
            end else if (w_capture) begin
                r_pc <= r_pc + 64'd4;
            end

            if (w_capture) begin
                r_fetch_count <= r_fetch_count + 32'd1;
            end
        end
    end

    if_id_register #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id (
        .clk           (clk),
        .reset         (reset),
        .i_load        (w_capture),
        .i_hold        (w_hold),
        .i_flush       (w_flush),
        .i_pc          (r_pc),
        .i_instruction (bus.Instruction),
        .o_pc          (bus.IF_ID_PC),
        .o_instruction (bus.IF_ID_Instruction),
        .o_valid       (bus.IF_ID_Valid)
    );

    assign bus.Inst_Address = r_pc;
    assign bus.Halted       = (r_state == c_HALTED);
    assign bus.Fetch_Count  = r_fetch_count;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instruction_fetch_stage
//  Purpose  : Self-checking bench. Three fetch stages (MEM_BYTES = 80, 78 and
//             2^64-1) share the same control stimulus; each is compared every
//             cycle against a behavioural model of the fetch rules.
//  Revision : 1.0  initial release
// ============================================================================
module tb_instruction_fetch_stage;
    import instruction_fetch_stage_pkg::*;

    localparam int NDUT = 3;
    localparam logic [63:0] MEM0 = 64'd80;
    localparam logic [63:0] MEM1 = 64'd78;
    localparam logic [63:0] MEM2 = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        br_taken;
    logic [63:0] br_target;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Arbitrary but deterministic memory contents, keyed by address.
    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h0000_0013;
    endfunction

    function automatic logic [63:0] mem_size(input int k);
        return (k == 0) ? MEM0 : (k == 1) ? MEM1 : MEM2;
    endfunction

    instruction_fetch_stage_if bus0 ();
    instruction_fetch_stage_if bus1 ();
    instruction_fetch_stage_if bus2 ();

    assign bus0.Stall = stall;  assign bus0.Branch_Taken = br_taken;  assign bus0.Branch_Target = br_target;
    assign bus1.Stall = stall;  assign bus1.Branch_Taken = br_taken;  assign bus1.Branch_Target = br_target;
    assign bus2.Stall = stall;  assign bus2.Branch_Taken = br_taken;  assign bus2.Branch_Target = br_target;
    assign bus0.Instruction = mem_word(bus0.Inst_Address);
    assign bus1.Instruction = mem_word(bus1.Inst_Address);
    assign bus2.Instruction = mem_word(bus2.Inst_Address);

    instruction_fetch_stage #(.RESET_PC(64'h0), .MEM_BYTES(MEM0), .NOP_INSTR(32'h0000_0013))
        dut0 (.clk(clk), .reset(reset), .bus(bus0));
    instruction_fetch_stage #(.RESET_PC(64'h0), .MEM_BYTES(MEM1), .NOP_INSTR(32'h0000_0013))
        dut1 (.clk(clk), .reset(reset), .bus(bus1));
    instruction_fetch_stage #(.RESET_PC(64'h0), .MEM_BYTES(MEM2), .NOP_INSTR(32'h0000_0013))
        dut2 (.clk(clk), .reset(reset), .bus(bus2));

    logic [63:0] o_addr [NDUT];
    logic [63:0] o_ifpc [NDUT];
    logic [31:0] o_inst [NDUT];
    logic        o_vld  [NDUT];
    logic        o_halt [NDUT];
    logic [31:0] o_cnt  [NDUT];

    assign o_addr[0] = bus0.Inst_Address; assign o_ifpc[0] = bus0.IF_ID_PC; assign o_inst[0] = bus0.IF_ID_Instruction;
    assign o_vld[0]  = bus0.IF_ID_Valid;  assign o_halt[0] = bus0.Halted;   assign o_cnt[0]  = bus0.Fetch_Count;
    assign o_addr[1] = bus1.Inst_Address; assign o_ifpc[1] = bus1.IF_ID_PC; assign o_inst[1] = bus1.IF_ID_Instruction;
    assign o_vld[1]  = bus1.IF_ID_Valid;  assign o_halt[1] = bus1.Halted;   assign o_cnt[1]  = bus1.Fetch_Count;
    assign o_addr[2] = bus2.Inst_Address; assign o_ifpc[2] = bus2.IF_ID_PC; assign o_inst[2] = bus2.IF_ID_Instruction;
    assign o_vld[2]  = bus2.IF_ID_Valid;  assign o_halt[2] = bus2.Halted;   assign o_cnt[2]  = bus2.Fetch_Count;

    // ---------------- behavioural reference ----------------
    logic [63:0] m_pc   [NDUT];
    logic [63:0] m_ifpc [NDUT];
    logic [31:0] m_inst [NDUT];
    logic        m_vld  [NDUT];
    logic        m_halt [NDUT];
    logic [31:0] m_cnt  [NDUT];

    task automatic model_update(input logic r, input logic st, input logic br, input logic [63:0] tgt);
        for (int k = 0; k < NDUT; k++) begin
            if (r) begin
                m_pc[k] = 64'h0; m_ifpc[k] = 64'h0; m_inst[k] = 32'h13;
                m_vld[k] = 1'b0; m_halt[k] = 1'b0; m_cnt[k] = 32'h0;
            end else if (br) begin
                m_pc[k]   = {tgt[63:2], 2'b00};
                m_inst[k] = 32'h13;
                m_vld[k]  = 1'b0;
                m_halt[k] = 1'b0;
            end else if (m_halt[k] || st) begin
                // nothing moves
            end else if ({1'b0, m_pc[k]} + 65'd3 >= {1'b0, mem_size(k)}) begin
                m_inst[k] = 32'h13;
                m_vld[k]  = 1'b0;
                m_halt[k] = 1'b1;
            end else begin
                m_ifpc[k] = m_pc[k];
                m_inst[k] = mem_word(m_pc[k]);
                m_vld[k]  = 1'b1;
                m_pc[k]   = m_pc[k] + 64'd4;
                m_cnt[k]  = m_cnt[k] + 32'd1;
            end
        end
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input logic chk_ifpc);
        for (int k = 0; k < NDUT; k++) begin
            check($sformatf("dut%0d.Inst_Address", k), o_addr[k], m_pc[k]);
            check($sformatf("dut%0d.IF_ID_Valid", k), {63'd0, o_vld[k]}, {63'd0, m_vld[k]});
            check($sformatf("dut%0d.IF_ID_Instruction", k), {32'd0, o_inst[k]}, {32'd0, m_inst[k]});
            check($sformatf("dut%0d.Halted", k), {63'd0, o_halt[k]}, {63'd0, m_halt[k]});
            check($sformatf("dut%0d.Fetch_Count", k), {32'd0, o_cnt[k]}, {32'd0, m_cnt[k]});
            // The PC held in IF/ID is only meaningful for a real instruction.
            if (chk_ifpc || m_vld[k])
                check($sformatf("dut%0d.IF_ID_PC", k), o_ifpc[k], m_ifpc[k]);
        end
    endtask

    // Drive inputs, clock once, advance the model, sample on the falling edge.
    task automatic step(input logic r, input logic st, input logic br, input logic [63:0] tgt);
        reset = r; stall = st; br_taken = br; br_target = tgt;
        @(posedge clk);
        model_update(r, st, br, tgt);
        @(negedge clk);
        check_all(r);
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; br_taken = 1'b0; br_target = '0;

        // Reset state, then straight-line fetch 0,4,8
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        check("tb.count_after_2", {32'd0, o_cnt[0]}, 64'd2);

        // Stall two cycles at PC=8, then release
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        check("tb.stall_ifpc", o_ifpc[0], 64'd4);
        step(0, 0, 0, 0);
        check("tb.release_ifpc", o_ifpc[0], 64'd8);
        check("tb.count_after_3", {32'd0, o_cnt[0]}, 64'd3);

        // Branch while stalled at PC=12: target 0x2E aligns to 0x2C
        step(0, 1, 1, 64'h2E);
        check("tb.branch_pc", o_addr[0], 64'h2C);
        step(0, 0, 0, 0);
        check("tb.after_branch_ifpc", o_ifpc[0], 64'h2C);

        // Run off the end of memory (80 for dut0, 76 halts dut1), hold there
        for (int i = 0; i < 12; i++) step(0, (i == 10), 0, 0);
        check("tb.halt_pc_80", o_addr[0], 64'd80);
        check("tb.halt_pc_76", o_addr[1], 64'd76);

        // Leave HALTED by branching to 0x10
        step(0, 0, 1, 64'h10);
        step(0, 0, 0, 0);
        check("tb.resume_ifpc", o_ifpc[0], 64'h10);

        // Reset mid-run with a branch also requested
        step(0, 0, 0, 0);
        step(1, 0, 1, 64'h40);
        check("tb.reset_over_branch_pc", o_addr[0], 64'h0);

        // Randomized mix of stalls, branches and occasional resets
        for (int i = 0; i < 400; i++) begin
            logic        r_r, r_st, r_br;
            logic [63:0] r_tgt;
            r_r   = ($urandom_range(0, 99) < 2);
            r_st  = ($urandom_range(0, 99) < 30);
            r_br  = ($urandom_range(0, 99) < 12);
            r_tgt = ($urandom_range(0, 9) == 0) ? {$urandom, $urandom}
                                                : 64'($urandom_range(0, 100));
            step(r_r, r_st, r_br, r_tgt);
        end

        // Top of the address space: the last full word below 2^64-1 is at
        // 2^64-8; the word at 2^64-4 would end on byte 2^64-1 and halts.
        step(0, 0, 1, 64'hFFFF_FFFF_FFFF_FFF8);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF);
        step(0, 0, 0, 0);

        // Fetch counter wraparound from 32'hFFFFFFFF to 0
        step(0, 0, 1, 64'h10);
        step(0, 1, 0, 0);
        force dut0.r_fetch_count = 32'hFFFF_FFFF;
        #1;
        release dut0.r_fetch_count;
        m_cnt[0] = 32'hFFFF_FFFF;
        step(0, 0, 0, 0);
        check("tb.count_wrap", {32'd0, o_cnt[0]}, 64'd0);
        step(0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
